// File: rtl/alarm_indicator_pkg.sv
// ---------------------------------------------------------------------------
// alarm_indicator_pkg
//   Shared types and constants for the alarm indicator sequencer.
//   - mode_e     : flash pattern select, encoded exactly as the 2-bit mode pin
//   - state_e    : sequencer states
//   - STROBE_SEQ : per-step strobe pattern, bit s is the level at step s
//                  (steps 0..7 read 1,0,1,0,1,0,0,0)
// ---------------------------------------------------------------------------
package alarm_indicator_pkg;

  typedef enum logic [1:0] {
    MODE_ALT    = 2'd0,
    MODE_CHASE  = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_STROBE = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [7:0] STROBE_SEQ = 8'b0001_0101;

endpackage

// File: rtl/alarm_tick_gen.sv
// ---------------------------------------------------------------------------
// alarm_tick_gen
//   Base-tick prescaler. Counts 0..TICK_DIV-1 and raises tick for the one
//   cycle in which the counter sits at its terminal value, so the consumer
//   acts on the same edge that wraps the counter.
//   Ports:
//     clk_in  in   system clock
//     rst_n   in   asynchronous active-low reset
//     clr     in   hold counter at 0 (and suppress tick) while high
//     tick    out  1-cycle pulse once every TICK_DIV cycles
// ---------------------------------------------------------------------------
module alarm_tick_gen #(
  parameter int TICK_DIV = 5_000_000
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = !clr && (cnt == CNT_LAST);

endmodule

// File: rtl/alarm_indicator_seq.sv
// ---------------------------------------------------------------------------
// alarm_indicator_seq
//   Drives NUM_CH indicator LEDs with one of four flash patterns while the
//   alarm request (enb) is high. An ack pulse snoozes the alarm; an optional
//   step-count timeout ends it automatically. Either way the block parks in
//   DONE until enb drops, so a new alarm needs a fresh enb rising edge.
//
//   Optional build macro ALARM_DIM_EN adds a 4-bit dim input that PWM-gates
//   every lit channel at duty (dim+1)/16.
//
//   Ports:
//     clk_in     in   system clock
//     rst_n      in   asynchronous active-low reset
//     enb        in   alarm request, level-sensitive
//     mode       in   pattern select (ALTERNATE, CHASE, BLINK_ALL, STROBE)
//     ack        in   single-cycle snooze/acknowledge pulse
//     dim        in   PWM brightness, only with ALARM_DIM_EN
//     led_out    out  LED drive, 1 = lit (registered)
//     active     out  high while running (registered)
//     timed_out  out  high in DONE when DONE was reached by timeout
// ---------------------------------------------------------------------------
module alarm_indicator_seq
  import alarm_indicator_pkg::*;
#(
  parameter int NUM_CH        = 2,
  parameter int TICK_DIV      = 5_000_000,
  parameter int PHASE_TICKS   = 4,
  parameter int TIMEOUT_STEPS = 0
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              enb,
  input  logic [1:0]        mode,
  input  logic              ack,
`ifdef ALARM_DIM_EN
  input  logic [3:0]        dim,
`endif
  output logic [NUM_CH-1:0] led_out,
  output logic              active,
  output logic              timed_out
);

  localparam int TCW = (PHASE_TICKS > 1) ? $clog2(PHASE_TICKS) : 1;
  localparam int SCW = (TIMEOUT_STEPS > 0) ? $clog2(TIMEOUT_STEPS + 1) : 1;
  localparam logic [TCW-1:0] TICK_LAST = TCW'(PHASE_TICKS - 1);
  localparam logic [SCW-1:0] SCNT_LAST = (TIMEOUT_STEPS > 0) ? SCW'(TIMEOUT_STEPS - 1) : '0;
  localparam logic [3:0]     CHASE_LAST = 4'(NUM_CH - 1);

  // Step index after s for the given mode; each mode has its own cycle length.
  function automatic logic [3:0] next_step(input mode_e m, input logic [3:0] s);
    logic [3:0] last;
    case (m)
      MODE_CHASE:  last = CHASE_LAST;
      MODE_STROBE: last = 4'd7;
      default:     last = 4'd1;
    endcase
    return (s == last) ? 4'd0 : s + 4'd1;
  endfunction

  // LED pattern shown at step s.
  function automatic logic [NUM_CH-1:0] pattern(input mode_e m, input logic [3:0] s);
    logic [NUM_CH-1:0] p;
    p = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      case (m)
        MODE_ALT:    p[i] = (i[0] == s[0]);  // even channels at s=0, odd at s=1
        MODE_CHASE:  p[i] = (4'(i) == s);
        MODE_BLINK:  p[i] = (s == 4'd0);
        MODE_STROBE: p[i] = STROBE_SEQ[s[2:0]];
        default:     p[i] = 1'b0;
      endcase
    end
    return p;
  endfunction

  state_e            state_q,    state_nxt;
  mode_e             mode_q,     mode_nxt;
  logic [TCW-1:0]    tick_cnt_q, tick_cnt_nxt;
  logic [3:0]        step_q,     step_nxt;
  logic [SCW-1:0]    scnt_q,     scnt_nxt;
  logic [NUM_CH-1:0] pat_q,      pat_nxt;
  logic              active_nxt, timed_out_nxt;
  logic              tick;
  logic              step_adv;

  // Prescaler is frozen at 0 outside RUN so every run starts on a clean phase.
  alarm_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .clr    (state_q != ST_RUN),
    .tick   (tick)
  );

  assign step_adv = tick && (tick_cnt_q == TICK_LAST);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave a signal unassigned and infer a latch.
    state_nxt     = state_q;
    mode_nxt      = mode_q;
    tick_cnt_nxt  = tick_cnt_q;
    step_nxt      = step_q;
    scnt_nxt      = scnt_q;
    pat_nxt       = pat_q;
    active_nxt    = active;
    timed_out_nxt = timed_out;

    if (!enb) begin
      // Dropping the request overrides ack and timeout from any state.
      state_nxt     = ST_IDLE;
      tick_cnt_nxt  = '0;
      step_nxt      = '0;
      scnt_nxt      = '0;
      pat_nxt       = '0;
      active_nxt    = 1'b0;
      timed_out_nxt = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_nxt     = ST_RUN;
          mode_nxt      = mode_e'(mode);
          tick_cnt_nxt  = '0;
          step_nxt      = '0;
          scnt_nxt      = '0;
          pat_nxt       = pattern(mode_e'(mode), 4'd0);
          active_nxt    = 1'b1;
          timed_out_nxt = 1'b0;
        end
        ST_RUN: begin
          if (ack) begin
            // Snooze wins over a timeout landing in the same cycle.
            state_nxt     = ST_DONE;
            tick_cnt_nxt  = '0;
            scnt_nxt      = '0;
            pat_nxt       = '0;
            active_nxt    = 1'b0;
            timed_out_nxt = 1'b0;
          end else if (step_adv) begin
            tick_cnt_nxt = '0;
            if (TIMEOUT_STEPS > 0 && scnt_q == SCNT_LAST) begin
              state_nxt     = ST_DONE;
              scnt_nxt      = '0;
              pat_nxt       = '0;
              active_nxt    = 1'b0;
              timed_out_nxt = 1'b1;
            end else begin
              step_nxt = next_step(mode_q, step_q);
              pat_nxt  = pattern(mode_q, next_step(mode_q, step_q));
              if (TIMEOUT_STEPS > 0) begin
                scnt_nxt = scnt_q + 1'b1;
              end
            end
          end else if (tick) begin
            tick_cnt_nxt = tick_cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          pat_nxt    = '0;
          active_nxt = 1'b0;
        end
        default: begin
          state_nxt     = ST_IDLE;
          pat_nxt       = '0;
          active_nxt    = 1'b0;
          timed_out_nxt = 1'b0;
        end
      endcase
    end
  end

  // NOTE: every flop here is a control/state register and is reset so the
  // outputs are defined from the moment rst_n asserts.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_ALT;
      tick_cnt_q <= '0;
      step_q     <= '0;
      scnt_q     <= '0;
      pat_q      <= '0;
      active     <= 1'b0;
      timed_out  <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      mode_q     <= mode_nxt;
      tick_cnt_q <= tick_cnt_nxt;
      step_q     <= step_nxt;
      scnt_q     <= scnt_nxt;
      pat_q      <= pat_nxt;
      active     <= active_nxt;
      timed_out  <= timed_out_nxt;
    end
  end

`ifdef ALARM_DIM_EN
  // Free-running PWM counter; the gate is evaluated on the value the counter
  // takes at the same edge, so led_out stays a registered output.
  logic [3:0]        pwm_cnt;
  logic [3:0]        pwm_nxt;
  logic [NUM_CH-1:0] led_q;

  assign pwm_nxt = pwm_cnt + 4'd1;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      led_q   <= '0;
    end else begin
      pwm_cnt <= pwm_nxt;
      led_q   <= (pwm_nxt <= dim) ? pat_nxt : '0;
    end
  end

  assign led_out = led_q;
`else
  assign led_out = pat_q;
`endif

endmodule

// File: tb/tb_alarm_indicator_seq.sv
// ---------------------------------------------------------------------------
// tb_alarm_indicator_seq
//   Self-checking bench for alarm_indicator_seq with TICK_DIV=4,
//   PHASE_TICKS=2 (8 cycles per pattern step). Separate instances cover
//   NUM_CH=2, NUM_CH=4, and NUM_CH=4 with a 5-step timeout; the dim
//   checks run only when ALARM_DIM_EN is defined.
// ---------------------------------------------------------------------------
module tb_alarm_indicator_seq;

  logic clk_in = 1'b0;
  logic rst_n;
  logic [3:0] dim;

  // NUM_CH=2 instance
  logic       enb2, ack2;
  logic [1:0] mode2;
  logic [1:0] led2;
  logic       act2, to2;

  // NUM_CH=4 instance, no timeout
  logic       enb4, ack4;
  logic [1:0] mode4;
  logic [3:0] led4;
  logic       act4, to4;

  // NUM_CH=4 instance, TIMEOUT_STEPS=5
  logic       enbt, ackt;
  logic [1:0] modet;
  logic [3:0] ledt;
  logic       actt, tot;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_in = ~clk_in;

  alarm_indicator_seq #(.NUM_CH(2), .TICK_DIV(4), .PHASE_TICKS(2), .TIMEOUT_STEPS(0)) dut2 (
    .clk_in (clk_in), .rst_n (rst_n), .enb (enb2), .mode (mode2), .ack (ack2),
`ifdef ALARM_DIM_EN
    .dim (dim),
`endif
    .led_out (led2), .active (act2), .timed_out (to2)
  );

  alarm_indicator_seq #(.NUM_CH(4), .TICK_DIV(4), .PHASE_TICKS(2), .TIMEOUT_STEPS(0)) dut4 (
    .clk_in (clk_in), .rst_n (rst_n), .enb (enb4), .mode (mode4), .ack (ack4),
`ifdef ALARM_DIM_EN
    .dim (dim),
`endif
    .led_out (led4), .active (act4), .timed_out (to4)
  );

  alarm_indicator_seq #(.NUM_CH(4), .TICK_DIV(4), .PHASE_TICKS(2), .TIMEOUT_STEPS(5)) dut_to (
    .clk_in (clk_in), .rst_n (rst_n), .enb (enbt), .mode (modet), .ack (ackt),
`ifdef ALARM_DIM_EN
    .dim (dim),
`endif
    .led_out (ledt), .active (actt), .timed_out (tot)
  );

`ifdef ALARM_DIM_EN
  // Longer step (32 cycles) so a full 16-cycle PWM window fits in one lit step.
  logic       enbd;
  logic [1:0] moded;
  logic [3:0] ledd;
  logic       actd, tod;
  logic       ackd;

  alarm_indicator_seq #(.NUM_CH(4), .TICK_DIV(4), .PHASE_TICKS(8), .TIMEOUT_STEPS(0)) dut_dim (
    .clk_in (clk_in), .rst_n (rst_n), .enb (enbd), .mode (moded), .ack (ackd),
    .dim (dim),
    .led_out (ledd), .active (actd), .timed_out (tod)
  );
`endif

  typedef struct {
    logic       enb;
    logic [1:0] mode;
    logic       ack;
    int         n;      // edges to advance after applying inputs
    logic [3:0] led;
    logic       act;
    logic       to;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Advance n rising edges and land 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    dim   = 4'hf;
    enb2 = 1'b0; ack2 = 1'b0; mode2 = 2'd0;
    enb4 = 1'b0; ack4 = 1'b0; mode4 = 2'd0;
    enbt = 1'b0; ackt = 1'b0; modet = 2'd0;
`ifdef ALARM_DIM_EN
    enbd = 1'b0; ackd = 1'b0; moded = 2'd2;
`endif

    // CHASE run, mode change mid-run ignored, then STROBE with snooze,
    // DONE hold, restart and full 8-step strobe cycle.
    //            enb   mode  ack  n   led      act   to
    vecs.push_back('{1'b0, 2'd1, 1'b0, 2, 4'b0000, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 2'd1, 1'b0, 1, 4'b0001, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 2'd1, 1'b0, 7, 4'b0001, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 2'd1, 1'b0, 1, 4'b0010, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 2'd2, 1'b0, 8, 4'b0100, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 2'd2, 1'b0, 8, 4'b1000, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 2'd2, 1'b0, 8, 4'b0001, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 1, 4'b0000, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 2'd3, 1'b0, 1, 4'b1111, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 2'd3, 1'b0, 8, 4'b0000, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 2'd3, 1'b0, 8, 4'b1111, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 2'd3, 1'b1, 1, 4'b0000, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 2'd3, 1'b0, 16, 4'b0000, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 2'd3, 1'b0, 1, 4'b0000, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 2'd3, 1'b0, 1, 4'b1111, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 2'd3, 1'b0, 8, 4'b0000, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 2'd3, 1'b0, 8, 4'b1111, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 2'd3, 1'b0, 8, 4'b0000, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 2'd3, 1'b0, 8, 4'b1111, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 2'd3, 1'b0, 8, 4'b0000, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 2'd3, 1'b0, 8, 4'b0000, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 2'd3, 1'b0, 8, 4'b0000, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 2'd3, 1'b0, 8, 4'b1111, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 2'd0, 1'b1, 1, 4'b0000, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 2'd0, 1'b0, 1, 4'b0000, 1'b0, 1'b0});

    // Reset, then 50 idle cycles with enb low on every instance.
    step(3);
    rst_n = 1'b1;
    for (int c = 0; c < 50; c++) begin
      step(1);
      check($sformatf("idle_c%0d", c),
            {16'h0, led2, act2, to2, led4, act4, to4, ledt, actt, tot}, 32'h0);
    end

    // ALTERNATE on two channels.
    enb2 = 1'b1; mode2 = 2'd0;
    step(1); check("alt_s0",      {led2, act2, to2}, {2'b01, 1'b1, 1'b0});
    step(7); check("alt_s0_hold", {led2, act2, to2}, {2'b01, 1'b1, 1'b0});
    step(1); check("alt_s1",      {led2, act2, to2}, {2'b10, 1'b1, 1'b0});
    step(8); check("alt_s0_wrap", {led2, act2, to2}, {2'b01, 1'b1, 1'b0});
    enb2 = 1'b0;
    step(1); check("alt_off",     {led2, act2, to2}, {2'b00, 1'b0, 1'b0});

    // Table-driven CHASE / STROBE / ack on the four-channel instance.
    for (int i = 0; i < vecs.size(); i++) begin
      enb4  = vecs[i].enb;
      mode4 = vecs[i].mode;
      ack4  = vecs[i].ack;
      step(vecs[i].n);
      check($sformatf("vec%0d", i), {led4, act4, to4},
            {vecs[i].led, vecs[i].act, vecs[i].to});
    end

    // Timeout after 5 step advances, BLINK_ALL.
    enbt = 1'b1; modet = 2'd2;
    step(1);  check("to_start",   {ledt, actt, tot}, {4'b1111, 1'b1, 1'b0});
    step(39); check("to_pre",     {ledt, actt, tot}, {4'b1111, 1'b1, 1'b0});
    step(1);  check("to_done",    {ledt, actt, tot}, {4'b0000, 1'b0, 1'b1});
    step(20); check("to_hold",    {ledt, actt, tot}, {4'b0000, 1'b0, 1'b1});
    enbt = 1'b0;
    step(1);  check("to_idle",    {ledt, actt, tot}, {4'b0000, 1'b0, 1'b0});
    // ack landing on the timeout edge: snooze wins.
    enbt = 1'b1;
    step(1);  check("to2_start",  {ledt, actt, tot}, {4'b1111, 1'b1, 1'b0});
    step(39);
    ackt = 1'b1;
    step(1);  check("to_ack_tie", {ledt, actt, tot}, {4'b0000, 1'b0, 1'b0});
    ackt = 1'b0;
    step(5);  check("to_ack_hold",{ledt, actt, tot}, {4'b0000, 1'b0, 1'b0});
    enbt = 1'b0;
    step(1);
    // enb drop on the timeout edge: back to IDLE, no timed_out.
    enbt = 1'b1;
    step(40);
    enbt = 1'b0; ackt = 1'b1;
    step(1);  check("to_enb_tie", {ledt, actt, tot}, {4'b0000, 1'b0, 1'b0});
    ackt = 1'b0;

`ifdef ALARM_DIM_EN
    begin
      int hi;
      int bad;
      hi = 0; bad = 0;
      dim = 4'd3; enbd = 1'b1; moded = 2'd2;
      step(1);
      for (int c = 0; c < 16; c++) begin
        if (ledd == 4'hf) hi++;
        else if (ledd != 4'h0) bad++;
        step(1);
      end
      check("dim3_high_cycles", hi, 4);
      check("dim3_uniform", bad, 0);
      dim = 4'd15;
      step(1);
      for (int c = 0; c < 10; c++) begin
        check($sformatf("dim15_c%0d", c), {ledd, actd, tod}, {4'hf, 1'b1, 1'b0});
        step(1);
      end
      enbd = 1'b0;
      step(1);
    end
`endif

    // Asynchronous reset in the middle of a run.
    enb2 = 1'b1; mode2 = 2'd0;
    step(1); check("rst_run_s0", {led2, act2, to2}, {2'b01, 1'b1, 1'b0});
    step(8); check("rst_run_s1", {led2, act2, to2}, {2'b10, 1'b1, 1'b0});
    rst_n = 1'b0;
    #2;      check("rst_async",  {led2, act2, to2}, {2'b00, 1'b0, 1'b0});
    step(1);
    rst_n = 1'b1;
    step(1); check("rst_resume", {led2, act2, to2}, {2'b01, 1'b1, 1'b0});
    step(8); check("rst_resume_s1", {led2, act2, to2}, {2'b10, 1'b1, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alarm_indicator_seq.md
Name: alarm_indicator_seq

Overview:
- Parametrised successor to the two-LED alarm siren.
- Drives NUM_CH indicator LEDs with one of four selectable flash patterns while the alarm is enabled.
- Adds an acknowledge (snooze) input and an optional auto-timeout.
- Sits between the alarm-compare logic (source of enb) and the board LED pins.

Parameters:
- NUM_CH, 2, number of LED channels; legal range 1..16.
- TICK_DIV, 5_000_000, clk_in cycles per base tick; must be >= 2.
- PHASE_TICKS, 4, base ticks per pattern step; must be >= 1.
- TIMEOUT_STEPS, 0, pattern steps before auto-off; 0 = never time out.

Ports:
- clk_in  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- enb  input  1  alarm request, level-sensitive.
- mode  input  2  pattern select: 0 ALTERNATE, 1 CHASE, 2 BLINK_ALL, 3 STROBE.
- ack  input  1  single-cycle snooze/acknowledge pulse.
- led_out  output  NUM_CH  LED drive, 1 = lit.
- active  output  1  high while in RUN.
- timed_out  output  1  high in DONE when DONE was reached by timeout.

Behaviour:
- Reset: state IDLE; led_out=0, active=0, timed_out=0; prescaler, tick and step counters all 0. All outputs are registered.
- State IDLE:
  - enb=1 sampled -> RUN on the next edge.
  - On that same edge: mode latched into mode_q, counters cleared, led_out loaded with step-0 pattern, active=1.
- State RUN:
  - Prescaler counts 0..TICK_DIV-1 and emits a 1-cycle tick on wrap.
  - Tick counter counts ticks 0..PHASE_TICKS-1; on wrap the step index advances and led_out updates on the same edge.
  - Step period = TICK_DIV*PHASE_TICKS cycles.
- Step index width and wrap by mode:
  - ALTERNATE wraps mod 2.
  - CHASE wraps mod NUM_CH.
  - BLINK_ALL wraps mod 2.
  - STROBE wraps mod 8.
- Patterns per step s:
  - ALTERNATE: s=0 lights even-index channels, s=1 lights odd-index channels. With NUM_CH=1, ch0 toggles.
  - CHASE: one-hot, bit s lit.
  - BLINK_ALL: all lit for s=0, all dark for s=1.
  - STROBE: all channels follow STROBE_SEQ[s] = 1,0,1,0,1,0,0,0.
- mode changes during RUN are ignored; mode_q holds until the next IDLE->RUN.
- Timeout: when TIMEOUT_STEPS>0, a step counter increments on each step advance. When it reaches TIMEOUT_STEPS, next state is DONE with timed_out=1.
- ack=1 in RUN -> DONE on the next edge, with timed_out=0.
- State DONE: led_out=0, active=0. DONE is left only when enb=0 (-> IDLE). A new alarm requires enb to drop and rise again.
- enb=0 in any state -> IDLE on the next edge: all outputs 0, counters cleared.
- Simultaneous events, in priority order:
  - enb=0 beats ack and timeout.
  - ack beats timeout in the same cycle (timed_out stays 0).
- ack in IDLE or DONE is ignored.
- rst_n asserted mid-RUN: outputs clear immediately (asynchronous); the block resumes from IDLE after release.

Optional Feature:
- Macro: ALARM_DIM_EN.
- Defined:
  - Adds input dim[3:0].
  - A free-running 4-bit PWM counter gates every lit channel; a lit channel is on while pwm_cnt <= dim, giving duty (dim+1)/16.
  - Dark channels stay 0.
  - dim is sampled every cycle.
- Undefined: no dim port; lit channels are driven steady 1.

Decomposition:
- alarm_indicator_pkg holds:
  - mode enum (MODE_ALT, MODE_CHASE, MODE_BLINK, MODE_STROBE);
  - state enum (ST_IDLE, ST_RUN, ST_DONE);
  - STROBE_SEQ 8-bit constant.
- Sub-module alarm_tick_gen:
  - Parameterised by TICK_DIV.
  - Inputs clk_in, rst_n, clr; output tick.
  - Counter held at 0 while clr=1.

Test Plan (sim params TICK_DIV=4, PHASE_TICKS=2, i.e. 8 cycles/step):
- Reset asserted, then released with enb=0 -> led_out=0, active=0, timed_out=0 for 50 cycles.
- NUM_CH=2, mode=0, enb 0->1 -> next edge led_out=2'b01, active=1; 8 cycles later 2'b10; 8 cycles later 2'b01.
- NUM_CH=4, mode=1 -> led_out sequence 0001, 0010, 0100, 1000, 0001 at 8-cycle spacing. Change mode to 2 mid-run -> sequence unchanged.
- mode=3 -> all channels follow 1,0,1,0,1,0,0,0 per step, then repeat. ack pulse at step 2 -> next edge led_out=0, active=0, timed_out=0. Drop and re-raise enb -> restarts at step 0.
- TIMEOUT_STEPS=5, mode=2 -> after 5 step advances (40 cycles) DONE with timed_out=1 and led_out=0. enb held 1 -> stays DONE. enb=0 -> IDLE, timed_out=0. ack and timeout in the same cycle -> timed_out=0.
- With ALARM_DIM_EN, dim=3, mode=2 at an all-lit step -> each channel high 4 of every 16 cycles. dim=15 -> steady high.
